// File: rtl/tmp_result_rx.sv
// tmp_result_rx
// Accumulates comparator decisions from a sensor front end into one
// conversion result. After start, SETTLE leading decisions are discarded,
// then 2^OSR_LOG2 decisions are summed. The sum is presented on res with a
// valid/ready handshake; a result that completes while an older one is still
// unaccepted is dropped and flagged on the sticky ovf output.
//
// Optional feature: define TMP_RX_AVG_EN to pair conversions. The first
// result of a pair is held internally, and the second presents the floor
// average of the two.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   start      single-cycle conversion request (ignored while busy)
//   cmp        comparator decision
//   cmp_strb   cmp valid this cycle
//   busy       conversion in progress
//   res        result (OSR_LOG2+1 bits)
//   res_valid  res holds an unaccepted result
//   res_ready  consumer accepts res
//   ovf        sticky: a result was dropped
//   clr_ovf    synchronous clear of ovf (a coincident set wins)
module tmp_result_rx #(
  parameter int unsigned OSR_LOG2 = 4,
  parameter int unsigned SETTLE   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmp,
  input  logic              cmp_strb,
  output logic              busy,
  output logic [OSR_LOG2:0] res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam int unsigned W = OSR_LOG2 + 1;
  localparam logic [W-1:0] LAST_DEC = W'((1 << OSR_LOG2) - 1);
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM
  } state_t;

  state_t       state, state_nx;
  logic [3:0]   set_cnt, set_cnt_nx;
  logic [W-1:0] cnt, cnt_nx;
  logic [W-1:0] acc, acc_nx;
  logic [W-1:0] sum;
  logic         done;
  logic         present;
  logic [W-1:0] pres_val;
  logic         accept;

  assign busy   = (state != ST_IDLE);
  assign accept = res_valid & res_ready;
  assign sum    = acc + {{OSR_LOG2{1'b0}}, cmp};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      set_cnt <= '0;
      cnt     <= '0;
      acc     <= '0;
    end else begin
      state   <= state_nx;
      set_cnt <= set_cnt_nx;
      cnt     <= cnt_nx;
      acc     <= acc_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    set_cnt_nx = set_cnt;
    cnt_nx     = cnt;
    acc_nx     = acc;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          set_cnt_nx = '0;
          cnt_nx     = '0;
          acc_nx     = '0;
          state_nx   = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cmp_strb) begin
          set_cnt_nx = set_cnt + 4'd1;
          if (set_cnt == SETTLE_LAST) state_nx = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (cmp_strb) begin
          cnt_nx = cnt + 1'b1;
          acc_nx = sum;
          // sum already includes this final strobe's decision
          if (cnt == LAST_DEC) begin
            done     = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef TMP_RX_AVG_EN
  logic         half;
  logic [W-1:0] r0;
  logic [W:0]   pair_sum;

  assign pair_sum = {1'b0, r0} + {1'b0, sum};
  assign present  = done & half;
  assign pres_val = pair_sum[W:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half <= 1'b0;
      r0   <= '0;
    end else if (done) begin
      half <= ~half;
      if (!half) r0 <= sum;
    end
  end
`else
  assign present  = done;
  assign pres_val = sum;
`endif

  // A new result may load when the holding register is empty or is being
  // emptied this very cycle; otherwise it is dropped and ovf is raised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res       <= '0;
      res_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (present && (!res_valid || accept)) begin
        res       <= pres_val;
        res_valid <= 1'b1;
      end else if (accept) begin
        res_valid <= 1'b0;
      end
      if (present && res_valid && !accept) ovf <= 1'b1;
      else if (clr_ovf)                    ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmp_result_rx.sv
module tb_tmp_result_rx;

  localparam int unsigned OSR = 4;
  localparam int unsigned SET = 2;
  localparam int unsigned NDEC = 1 << OSR;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         cmp;
  logic         cmp_strb;
  logic         busy;
  logic [OSR:0] res;
  logic         res_valid;
  logic         res_ready;
  logic         ovf;
  logic         clr_ovf;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  // pairing state of the reference model (used only when averaging is built in)
  bit pair_half = 1'b0;
  int pair_r0   = 0;

  tmp_result_rx #(.OSR_LOG2(OSR), .SETTLE(SET)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cmp       (cmp),
    .cmp_strb  (cmp_strb),
    .busy      (busy),
    .res       (res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: a conversion's value is the number of ones among its
  // accumulated decisions; with pairing, every second conversion yields the
  // floor mean of the pair.
  task automatic model_result(input int value, input bit drop);
`ifdef TMP_RX_AVG_EN
    if (!pair_half) begin
      pair_r0   = value;
      pair_half = 1'b1;
    end else begin
      pair_half = 1'b0;
      if (!drop) exp_q.push_back((pair_r0 + value) / 2);
    end
`else
    if (!drop) exp_q.push_back(value);
`endif
  endtask

  // One full conversion. gaps>0 inserts random idle cycles with random
  // ready and stray start pulses (the DUT is busy then, so they are ignored).
  task automatic convert(input logic [15:0] bits, input logic [1:0] sb,
                         input int gaps, input bit final_ready,
                         input bit drop, input bit clr_final);
    start = 1'b1; cmp_strb = 1'b0; step();
    start = 1'b0;
    for (int i = 0; i < int'(SET + NDEC); i++) begin
      if (gaps > 0) begin
        repeat ($urandom_range(0, gaps)) begin
          cmp_strb  = 1'b0;
          cmp       = 1'($urandom);
          start     = ($urandom_range(0, 4) == 0);
          res_ready = 1'($urandom);
          step();
        end
        start = 1'b0;
      end
      cmp_strb = 1'b1;
      cmp      = (i < int'(SET)) ? sb[i] : bits[i - SET];
      if (i == int'(SET + NDEC) - 1) begin
        check("busy_before_final", int'(busy), 1);
        if (final_ready) res_ready = 1'b1;
        if (clr_final) clr_ovf = 1'b1;
        if (gaps > 0) start = 1'($urandom);
        model_result($countones(bits), drop);
      end
      step();
    end
    cmp_strb  = 1'b0;
    start     = 1'b0;
    clr_ovf   = 1'b0;
    res_ready = 1'b0;
  endtask

  // Monitor: every accepted result is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got res=%0d expected no result", res);
        end else begin
          check("scoreboard_res", int'(res), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; cmp = 1'b0; cmp_strb = 1'b0;
    res_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(res_valid), 0);
    check("reset_res", int'(res), 0);
    check("reset_ovf", int'(ovf), 0);
    step();
    reset = 1'b0;
    step();

`ifndef TMP_RX_AVG_EN
    // all ones after two zero settle decisions
    convert(16'hFFFF, 2'b00, 0, 1'b0, 1'b0, 1'b0);
    check("full_valid", int'(res_valid), 1);
    check("full_busy", int'(busy), 0);
    check("full_res", int'(res), 16);

    // second result while the first is pending -> dropped
    convert(16'h0000, 2'b10, 0, 1'b0, 1'b1, 1'b0);
    check("drop_res_kept", int'(res), 16);
    check("drop_valid", int'(res_valid), 1);
    check("drop_ovf", int'(ovf), 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("clr_ovf", int'(ovf), 0);

    // drop coinciding with clr_ovf: set wins
    convert(16'h1234, 2'b01, 0, 1'b0, 1'b1, 1'b1);
    check("set_wins_ovf", int'(ovf), 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("clr_ovf2", int'(ovf), 0);

    // alternating decisions, settle ones ignored, accepted in completion cycle
    convert(16'h5555, 2'b11, 0, 1'b1, 1'b0, 1'b0);
    check("alt_res", int'(res), 8);
    check("alt_valid", int'(res_valid), 1);
    check("alt_ovf", int'(ovf), 0);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    check("valid_drop_after_accept", int'(res_valid), 0);

    // reset during accumulation, with a result pending
    convert(16'h00F0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    cmp_strb = 1'b1;
    for (int i = 0; i < int'(SET) + 7; i++) begin
      cmp = 1'b1;
      step();
    end
    cmp_strb = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_valid", int'(res_valid), 0);
    check("rst_mid_res", int'(res), 0);
    exp_q.delete();
    step(); step();
    reset = 1'b0;
    // strobes without start must not produce anything
    for (int i = 0; i < 40; i++) begin
      cmp_strb  = 1'($urandom);
      cmp       = 1'($urandom);
      res_ready = 1'b1;
      step();
    end
    cmp_strb = 1'b0; res_ready = 1'b0;
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(res_valid), 0);
`else
    // paired conversions 11 and 6 -> single result 8
    convert(16'h07FF, 2'b00, 0, 1'b0, 1'b0, 1'b0);
    check("avg_first_hidden", int'(res_valid), 0);
    convert(16'h003F, 2'b11, 0, 1'b0, 1'b0, 1'b0);
    check("avg_valid", int'(res_valid), 1);
    check("avg_res", int'(res), 8);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    check("avg_valid_drop", int'(res_valid), 0);
`endif

    // randomized conversions with random consumer timing
    for (int n = 0; n < 30; n++) begin
      logic [15:0] b;
      logic [1:0]  s;
      b = 16'($urandom);
      s = 2'($urandom);
      convert(b, s, 3, 1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        cmp_strb  = 1'($urandom);
        cmp       = 1'($urandom);
        res_ready = 1'($urandom);
        step();
      end
      cmp_strb = 1'b0;
    end
    res_ready = 1'b1;
    repeat (5) step();
    res_ready = 1'b0;
    check("rand_ovf", int'(ovf), 0);
    check("drain_valid", int'(res_valid), 0);
    check("drain_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
